// File: rtl/goertzel_pkg.sv
// Shared types and widths for the four-bin Goertzel engine.
package goertzel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        POW,
        OUT
    } state_t;

    localparam int SAMPLE_W = 16;
    localparam int STATE_W  = 32;
    localparam int POWER_W  = 64;
    localparam int COEFF_W  = 16;
    localparam int Q_FRAC   = 14;

endpackage

// File: rtl/goertzel_mult.sv
// Shared signed 32x32->64 multiplier, purely combinational (zero latency).
// No flow control: operands are muxed by the parent every cycle.
module goertzel_mult
    import goertzel_pkg::*;
(
    input  logic signed [STATE_W-1:0]   a,
    input  logic signed [STATE_W-1:0]   b,
    output logic signed [POWER_W-1:0]   product
);

    assign product = a * b;

endmodule

// File: rtl/goertzel_sequencer.sv
// Time-multiplexed four-bin Goertzel engine: 4 cycles per sample, +17 cycles for powers.
// sample_ready is high only in IDLE; samples offered while busy wait for the next IDLE cycle.
module goertzel_sequencer
    import goertzel_pkg::*;
#(
    parameter int                          BLOCK_LEN = 205,
    parameter int                          CNT_W     = 8,
    parameter logic signed [COEFF_W-1:0]   COEFF_1   = 16'sd0,
    parameter logic signed [COEFF_W-1:0]   COEFF_2   = 16'sd0,
    parameter logic signed [COEFF_W-1:0]   COEFF_3   = 16'sd0,
    parameter logic signed [COEFF_W-1:0]   COEFF_4   = 16'sd0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [SAMPLE_W-1:0]     sample,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [POWER_W-1:0]      power_1,
    output logic [POWER_W-1:0]      power_2,
    output logic [POWER_W-1:0]      power_3,
    output logic [POWER_W-1:0]      power_4,
    output logic                    advance,
    output logic                    busy
);

    state_t                     state;
    state_t                     state_nxt;
    logic [1:0]                 bin;
    logic [1:0]                 phase;
    logic [CNT_W-1:0]           n;
    logic signed [SAMPLE_W-1:0] x;
    logic signed [STATE_W-1:0]  s1 [4];
    logic signed [STATE_W-1:0]  s2 [4];
    logic signed [STATE_W-1:0]  t;
    logic signed [POWER_W-1:0]  acc;
    logic [POWER_W-1:0]         shadow [3];
    logic [POWER_W-1:0]         power_q [4];

    logic signed [STATE_W-1:0]  coeff;
    logic signed [STATE_W-1:0]  mul_a;
    logic signed [STATE_W-1:0]  mul_b;
    logic signed [POWER_W-1:0]  prod;
    logic signed [STATE_W-1:0]  prod_q;
    logic signed [STATE_W-1:0]  s_new;
    logic [POWER_W-1:0]         pow_last;
    logic                       last_sample;
    logic                       pow_done;

    always_comb begin
        coeff = '0;
        case (bin)
            2'd0:    coeff = STATE_W'(COEFF_1);
            2'd1:    coeff = STATE_W'(COEFF_2);
            2'd2:    coeff = STATE_W'(COEFF_3);
            default: coeff = STATE_W'(COEFF_4);
        endcase
    end

    // Operand mux: one product per cycle in ITER/POW, tied to zero otherwise.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == ITER) begin
            mul_a = coeff;
            mul_b = s1[bin];
        end else if (state == POW) begin
            case (phase)
                2'd0:    begin mul_a = s1[bin]; mul_b = s1[bin]; end
                2'd1:    begin mul_a = s2[bin]; mul_b = s2[bin]; end
                2'd2:    begin mul_a = coeff;   mul_b = s1[bin]; end
                default: begin mul_a = t;       mul_b = s2[bin]; end
            endcase
        end
    end

    goertzel_mult u_mult (
        .a       (mul_a),
        .b       (mul_b),
        .product (prod)
    );

    // Arithmetic shift by Q_FRAC then truncate to 32 bits is just this bit slice.
    assign prod_q      = prod[Q_FRAC+STATE_W-1:Q_FRAC];
    assign s_new       = STATE_W'(x) + prod_q - s2[bin];
    assign pow_last    = acc - prod;
    assign last_sample = (n == CNT_W'(BLOCK_LEN - 1));
    assign pow_done    = (phase == 2'd3) && (bin == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample_valid) state_nxt = ITER;
                ITER:    if (bin == 2'd3) state_nxt = last_sample ? POW : IDLE;
                POW:     if (pow_done) state_nxt = OUT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin   <= '0;
            phase <= '0;
            n     <= '0;
            x     <= '0;
            t     <= '0;
            acc   <= '0;
            for (int i = 0; i < 4; i++) begin
                s1[i]      <= '0;
                s2[i]      <= '0;
                power_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else if (clear) begin
            bin   <= '0;
            phase <= '0;
            n     <= '0;
            t     <= '0;
            acc   <= '0;
            for (int i = 0; i < 4; i++) begin
                s1[i] <= '0;
                s2[i] <= '0;
            end
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        x   <= sample;
                        bin <= '0;
                    end
                end
                ITER: begin
                    s2[bin] <= s1[bin];
                    s1[bin] <= s_new;
                    bin     <= bin + 2'd1;
                    if (bin == 2'd3) n <= last_sample ? '0 : n + 1'b1;
                end
                POW: begin
                    phase <= phase + 2'd1;
                    case (phase)
                        2'd0: acc <= prod;
                        2'd1: acc <= acc + prod;
                        2'd2: t   <= prod_q;
                        default: begin
                            bin <= bin + 2'd1;
                            // Last bin bypasses its shadow so power_* is already valid during OUT.
                            if (bin == 2'd3) begin
                                for (int i = 0; i < 3; i++) power_q[i] <= shadow[i];
                                power_q[3] <= pow_last;
                            end else begin
                                shadow[bin] <= pow_last;
                            end
                        end
                    endcase
                end
                default: begin
                    for (int i = 0; i < 4; i++) begin
                        s1[i] <= '0;
                        s2[i] <= '0;
                    end
                end
            endcase
        end
    end

    assign sample_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign advance      = (state == OUT) && !clear;
    assign power_1      = power_q[0];
    assign power_2      = power_q[1];
    assign power_3      = power_q[2];
    assign power_4      = power_q[3];

endmodule

// File: tb/tb_goertzel_sequencer.sv
// Randomized block-level bench for goertzel_sequencer against a plain-arithmetic Goertzel model.
module tb_goertzel_sequencer;

    localparam int BL = 4;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [63:0] power_1;
    logic [63:0] power_2;
    logic [63:0] power_3;
    logic [63:0] power_4;
    logic        advance;
    logic        busy;

    int     n_vec = 0;
    int     n_err = 0;
    int     blk [BL];
    int     cf [4] = '{16384, 32767, -23170, 0};
    longint exp_pw [4];
    longint last_pw [4] = '{0, 0, 0, 0};

    goertzel_sequencer #(
        .BLOCK_LEN (BL),
        .CNT_W     (3),
        .COEFF_1   (16'sd16384),
        .COEFF_2   (16'sd32767),
        .COEFF_3   (-16'sd23170),
        .COEFF_4   (16'sd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .power_1      (power_1),
        .power_2      (power_2),
        .power_3      (power_3),
        .power_4      (power_4),
        .advance      (advance),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pw_out(input int b);
        case (b)
            0:       return power_1;
            1:       return power_2;
            2:       return power_3;
            default: return power_4;
        endcase
    endfunction

    // Direct Goertzel over the whole block: recurrence, then |X|^2 = s1^2 + s2^2 - c*s1*s2.
    task automatic model_block();
        int     s1, s2, sn, tq;
        for (int b = 0; b < 4; b++) begin
            s1 = 0;
            s2 = 0;
            for (int i = 0; i < BL; i++) begin
                sn = blk[i] + int'((longint'(cf[b]) * longint'(s1)) >>> 14) - s2;
                s2 = s1;
                s1 = sn;
            end
            tq = int'((longint'(cf[b]) * longint'(s1)) >>> 14);
            exp_pw[b] = longint'(s1) * longint'(s1) + longint'(s2) * longint'(s2)
                        - longint'(tq) * longint'(s2);
        end
    endtask

    // Called at a negedge; returns #1 after the handshake edge.
    task automatic send(input int xv, input bit hold);
        int g;
        sample       = 16'(xv);
        sample_valid = 1'b1;
        g = 0;
        while (!sample_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_eq("rdy_seen", 64'(sample_ready), 64'd1);
        @(posedge clk);
        #1;
        if (hold) sample = 16'($urandom);
        else      sample_valid = 1'b0;
    endtask

    task automatic run_block(input bit hold, input int abort_at);
        int g;
        int advs;
        for (int i = 0; i < BL; i++) begin
            send(blk[i], hold && (i < BL - 1));
            if (i < BL - 1) begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!sample_ready && g < 20);
                check_eq("rdy_lat", 64'(g), 64'd5);
            end
        end
        model_block();
        if (abort_at == 0) begin
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!advance && g < 40);
            check_eq("adv_lat", 64'(g), 64'd21);
            for (int b = 0; b < 4; b++) begin
                check_eq($sformatf("pw%0d", b + 1), pw_out(b), 64'(exp_pw[b]));
                last_pw[b] = exp_pw[b];
            end
            check_eq("no_x", 64'($isunknown({power_1, power_2, power_3, power_4, advance, busy})), 64'd0);
            @(negedge clk);
            check_eq("adv_pulse", 64'(advance), 64'd0);
            check_eq("rdy_after", 64'(sample_ready), 64'd1);
        end else begin
            repeat (abort_at) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            check_eq("clr_idle", 64'(sample_ready), 64'd1);
            check_eq("clr_busy", 64'(busy), 64'd0);
            advs = 0;
            repeat (30) begin
                @(negedge clk);
                if (advance) advs++;
            end
            check_eq("clr_noadv", 64'(advs), 64'd0);
            for (int b = 0; b < 4; b++)
                check_eq($sformatf("clr_hold%0d", b + 1), pw_out(b), 64'(last_pw[b]));
        end
    endtask

    task automatic rand_blk();
        for (int i = 0; i < BL; i++) blk[i] = int'($urandom_range(65535)) - 32768;
    endtask

    initial begin
        reset        = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_pw", power_1 | power_2 | power_3 | power_4, 64'd0);
        check_eq("rst_adv", 64'(advance), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rdy", 64'(sample_ready), 64'd1);
        reset = 1'b1;
        @(negedge clk);

        blk = '{100, 0, 0, 0};
        run_block(1'b0, 0);
        check_eq("tone_b4", power_4, 64'd10000);

        blk = '{1, 0, 0, 0};
        run_block(1'b0, 0);
        check_eq("imp_b1", power_1, 64'd1);
        check_eq("imp_b4", power_4, 64'd1);

        blk = '{-32768, -32768, -32768, -32768};
        run_block(1'b1, 0);

        for (int r = 0; r < 6; r++) begin
            rand_blk();
            run_block(r[0], 0);
        end

        // Abort during POW cycle 7 (handshake + 12), then a clean block.
        rand_blk();
        run_block(1'b0, 12);
        rand_blk();
        run_block(1'b1, 0);

        // Asynchronous reset in the middle of ITER.
        rand_blk();
        send(blk[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("arst_pw", power_1 | power_2 | power_3 | power_4, 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_rdy", 64'(sample_ready), 64'd1);
        for (int b = 0; b < 4; b++) last_pw[b] = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("arst_rel_rdy", 64'(sample_ready), 64'd1);
        rand_blk();
        run_block(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/goertzel_sequencer.md
# goertzel_sequencer

Time-multiplexed Goertzel engine feeding the four-bin tone detector. Accepts one audio sample at a time over a valid/ready handshake and runs the Goertzel recurrence for four bins through one shared signed multiplier. After BLOCK_LEN samples it computes the four bin powers, presents them to the detector with a one-cycle `advance` strobe, clears state and starts the next block.

## Interface
- `BLOCK_LEN`, 205: samples per block, ≥2.
- `CNT_W`, 8: sample-counter width; 2^CNT_W > BLOCK_LEN.
- `COEFF_1`..`COEFF_4`, 16'sd0: per-bin 2·cos(ω) coefficient, signed Q2.14.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `clear` in 1: synchronous abort; discards the partial block.
- `sample` in 16: signed audio sample.
- `sample_valid` in 1: `sample` is valid.
- `sample_ready` out 1: high only in IDLE.
- `power_1`..`power_4` out 64: signed bin powers, held between blocks.
- `advance` out 1: one-cycle pulse when `power_*` update.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- State registers per bin k: `s1[k]`, `s2[k]`, 32-bit signed. Counter `n`, CNT_W bits. Power accumulator `acc`, 64-bit.
- States: IDLE, ITER, POW, OUT.
- IDLE: `sample_ready`=1. A handshake (`sample_valid` && `sample_ready`) latches `sample` and moves to ITER with bin index 0.
- ITER: one bin per cycle, k=0..3.
  - `s_new = sext(x) + ((COEFF_k * s1[k]) >>> 14) - s2[k]`, product 64-bit, result truncated to 32 bits (wraps).
  - Update `s2[k] <= s1[k]`, `s1[k] <= s_new`.
  - After k=3: increment `n`. If `n` was BLOCK_LEN-1, go to POW and clear `n`; otherwise go to IDLE.
- POW: four cycles per bin, bins 1..4 in order, 16 cycles total.
  - Cycle 0: `acc = s1*s1`.
  - Cycle 1: `acc += s2*s2`.
  - Cycle 2: `t = (COEFF*s1) >>> 14`, truncated to 32 bits.
  - Cycle 3: `power_k_next = acc - t*s2`.
  - All arithmetic is modulo 2^64. Results go to internal shadow registers.
- OUT: one cycle.
  - Copy shadows to `power_1..4`, pulse `advance`.
  - Zero all `s1`/`s2`.
  - Return to IDLE.
- Multiplier: exactly one multiply per cycle in ITER and POW, none in IDLE or OUT.
- `clear` wins over all other activity in any state:
  - Next state IDLE; zero `s1`, `s2`, `n`, `acc` and the shadows.
  - `power_*` hold their values; `advance` stays 0.
  - A handshake in the same cycle as `clear` is dropped.
- Reset: all state, counters and `power_*` = 0; `advance`=0; `busy`=0; state IDLE, so `sample_ready`=1 immediately after reset release. Reset mid-block discards everything.

## Timing
- Handshake at cycle t: ITER occupies t+1..t+4 (bin k updates at t+1+k).
- Non-final sample: IDLE and `sample_ready`=1 at t+5. Throughput is one sample per 5 cycles.
- Final sample: POW occupies t+5..t+20, OUT at t+21.
  - `advance`=1 and new `power_*` visible during t+21; `advance` is 0 otherwise.
  - `sample_ready`=1 again at t+22.
- `sample_ready` is combinational from state (plus `!clear` gating is not applied; `clear` simply drops the handshake).
- `sample_valid` held while `sample_ready`=0 causes no action; the sample is taken at the next IDLE cycle.
- Block latency from first handshake with back-to-back input is 5·BLOCK_LEN + 17 cycles.

## Structure
- Shared package `goertzel_pkg`:
  - `state_t` enum (IDLE, ITER, POW, OUT).
  - Widths: SAMPLE_W=16, STATE_W=32, POWER_W=64, COEFF_W=16.
  - Q-format shift constant Q_FRAC=14.
- Sub-module `goertzel_mult`: combinational signed 32×32→64 multiplier. It is the only multiplier instance; operand muxing is in the parent.

## Test plan
- BLOCK_LEN=4, all COEFF=0; samples 100,0,0,0 back-to-back -> `advance` once, 21 cycles after the 4th handshake; `power_1..4`=10000.
- BLOCK_LEN=4, COEFF_1=16384 (1.0), others 0; samples 1,0,0,0 -> `power_1`=1, `power_2..4`=1.
- Hold `sample_valid`=1 continuously -> `sample_ready` pattern is 1,0,0,0,0 repeating; no sample is lost or double-counted; `n` is correct across blocks.
- Assert `clear` during POW cycle 7 of a block with non-zero powers in flight -> IDLE next cycle, no `advance`, `power_*` keep the previous block's values; next full block matches a fresh-reset run.
- Assert `reset` low mid-ITER -> all outputs 0 asynchronously, `sample_ready`=1 after release; the following block result equals the golden model.
- Negative full-scale input (-32768 for 205 samples, COEFF=32767) -> results match a bit-exact wraparound golden model; no X on any output.
